// File: rtl/proto_display_pkg.sv
// proto_display_pkg
//   Shared definitions for the face pixel buffer display path.
//   - DEF_LOG_POWER_MOD : default bits per colour channel (= number of BCM planes)
//   - pixel_size()      : width of one packed pixel word, {R, G, B}
//   - r_offset/g_offset : LSB position of the R and G fields (B always sits at bit 0)
//   - SCAN_STATE        : state encoding of the panel scan FSM
//   - pixel_addr()      : linear buffer address of (row, col)
package proto_display_pkg;

    localparam int DEF_LOG_POWER_MOD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        SHOW  = 2'd3
    } SCAN_STATE;

    function automatic int pixel_size(input int log_power_mod);
        return 3 * log_power_mod;
    endfunction

    function automatic int r_offset(input int log_power_mod);
        return 2 * log_power_mod;
    endfunction

    function automatic int g_offset(input int log_power_mod);
        return log_power_mod;
    endfunction

    // Evaluated at 32 bits so the product never wraps before the caller
    // narrows it to the real address width.
    function automatic int unsigned pixel_addr(input int unsigned row,
                                               input int unsigned col,
                                               input int unsigned num_pixels);
        return row * num_pixels + col;
    endfunction

endpackage

// File: rtl/bcm_timer.sv
// bcm_timer
//   Loadable down-counter that times one BCM display phase.
//   Ports:
//     clk_in  - system clock
//     rst_in  - asynchronous active-low reset
//     load    - load BASE_TICKS << plane on this cycle
//     plane   - bit plane whose weight is loaded
//     done    - high while the counter is at zero
//   The top pulses load on the last SHIFT cycle, so the count passes through
//   the LATCH cycle and reaches zero exactly on the final SHOW cycle.
module bcm_timer
    import proto_display_pkg::*;
#(
    parameter int  BASE_TICKS    = 64,
    parameter int  LOG_POWER_MOD = DEF_LOG_POWER_MOD,
    localparam int PLANE_W       = $clog2(LOG_POWER_MOD),
    localparam int CNT_W         = $clog2(BASE_TICKS << (LOG_POWER_MOD - 1)) + 1
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               load,
    input  logic [PLANE_W-1:0] plane,
    output logic               done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(BASE_TICKS) << plane;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/hub75_scan_reader.sv
// hub75_scan_reader
//   Read side of the face pixel buffer. Scans the buffer row by row and drives
//   a HUB75 panel using binary-code modulation over LOG_POWER_MOD bit planes.
//   Each (row, plane) pair is one SHIFT -> LATCH -> SHOW pass; a frame is
//   NUM_BLOCK_ROWS * LOG_POWER_MOD passes.
//   Ports:
//     clk_in, rst_in        - clock, asynchronous active-low reset
//     enable_in             - run frames while high (checked at frame boundaries)
//     pixel_rd_addr         - buffer read address, row*NUM_PIXELS+col
//     pixel_rd_data         - buffer word {R,G,B}, valid RD_LATENCY cycles after addr
//     r_out, g_out, b_out   - selected plane bit of the current column
//     panel_clk_out         - column shift clock, one cycle high per column
//     latch_out             - one-cycle latch pulse after each row shift
//     oe_n_out              - active-low output enable, low only during SHOW
//     row_addr_out          - row currently latched on the panel
//     frame_start           - pulse on the first SHIFT cycle of row 0 / plane 0
//     busy                  - high whenever the scanner is not idle
module hub75_scan_reader
    import proto_display_pkg::*;
#(
    parameter int  NUM_BLOCK_ROWS = 16,
    parameter int  NUM_PIXELS     = 128,
    parameter int  LOG_POWER_MOD  = DEF_LOG_POWER_MOD,
    parameter int  RD_LATENCY     = 2,
    parameter int  BASE_TICKS     = 64,
    localparam int ADDR_W         = $clog2(NUM_BLOCK_ROWS * NUM_PIXELS),
    localparam int ROW_W          = $clog2(NUM_BLOCK_ROWS),
    localparam int PIX_W          = pixel_size(LOG_POWER_MOD)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              enable_in,
    output logic [ADDR_W-1:0] pixel_rd_addr,
    input  logic [PIX_W-1:0]  pixel_rd_data,
    output logic              r_out,
    output logic              g_out,
    output logic              b_out,
    output logic              panel_clk_out,
    output logic              latch_out,
    output logic              oe_n_out,
    output logic [ROW_W-1:0]  row_addr_out,
    output logic              frame_start,
    output logic              busy
);

    localparam int COL_W   = $clog2(NUM_PIXELS);
    localparam int PLANE_W = $clog2(LOG_POWER_MOD);
    localparam int T_W     = $clog2(2 * NUM_PIXELS + RD_LATENCY + 1);
    localparam int R_LSB   = r_offset(LOG_POWER_MOD);
    localparam int G_LSB   = g_offset(LOG_POWER_MOD);

    // Last SHIFT cycle is the final column's panel clock.
    localparam logic [T_W-1:0]     T_LAST      = T_W'(2 * NUM_PIXELS + RD_LATENCY);
    localparam logic [T_W-1:0]     T_ISSUE_END = T_W'(2 * NUM_PIXELS);
    localparam logic [COL_W-1:0]   COL_LAST    = COL_W'(NUM_PIXELS - 1);
    localparam logic [PLANE_W-1:0] PLANE_LAST  = PLANE_W'(LOG_POWER_MOD - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST    = ROW_W'(NUM_BLOCK_ROWS - 1);

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
        return ADDR_W'(pixel_addr(32'(row), 32'(col), NUM_PIXELS));
    endfunction

    SCAN_STATE          state_q;
    logic [T_W-1:0]     t_q;
    logic [COL_W-1:0]   col_q;
    logic [ROW_W-1:0]   row_q;
    logic [PLANE_W-1:0] plane_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               latch_q;
    logic               oe_n_q;
    logic [ROW_W-1:0]   row_out_q;
    logic               frame_start_q;

    logic               plane_wrap;
    logic               frame_end;
    logic [ROW_W-1:0]   next_row;
    logic               timer_load;
    logic               timer_done;
    logic               col_issue;

    assign plane_wrap = (plane_q == PLANE_LAST);
    assign frame_end  = plane_wrap && (row_q == ROW_LAST);
    assign next_row   = !plane_wrap ? row_q :
                        ((row_q == ROW_LAST) ? '0 : row_q + 1'b1);

    assign timer_load = (state_q == SHIFT) && (t_q == T_LAST);

    // A new column address is presented on every even SHIFT cycle.
    assign col_issue  = (state_q == SHIFT) && !t_q[0] && (t_q < T_ISSUE_END);

    bcm_timer #(
        .BASE_TICKS   (BASE_TICKS),
        .LOG_POWER_MOD(LOG_POWER_MOD)
    ) u_bcm_timer (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .load  (timer_load),
        .plane (plane_q),
        .done  (timer_done)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            t_q           <= '0;
            col_q         <= '0;
            row_q         <= '0;
            plane_q       <= '0;
            addr_q        <= '0;
            latch_q       <= 1'b0;
            oe_n_q        <= 1'b1;
            row_out_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            latch_q       <= 1'b0;
            frame_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    oe_n_q <= 1'b1;
                    if (enable_in) begin
                        state_q       <= SHIFT;
                        t_q           <= '0;
                        col_q         <= '0;
                        row_q         <= '0;
                        plane_q       <= '0;
                        addr_q        <= addr_of('0, '0);
                        frame_start_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (t_q == T_LAST) begin
                        state_q   <= LATCH;
                        latch_q   <= 1'b1;
                        row_out_q <= row_q;
                    end else begin
                        t_q <= t_q + 1'b1;
                        // Odd cycle: advance so the next even cycle sees the new column.
                        if (t_q[0] && (col_q != COL_LAST)) begin
                            col_q  <= col_q + 1'b1;
                            addr_q <= addr_of(row_q, col_q + 1'b1);
                        end
                    end
                end
                LATCH: begin
                    state_q <= SHOW;
                    oe_n_q  <= 1'b0;
                end
                SHOW: begin
                    if (timer_done) begin
                        oe_n_q  <= 1'b1;
                        plane_q <= plane_wrap ? '0 : plane_q + 1'b1;
                        row_q   <= next_row;
                        t_q     <= '0;
                        col_q   <= '0;
                        addr_q  <= addr_of(next_row, '0);
                        // enable_in only matters once a whole frame has been shown.
                        if (!frame_end || enable_in) begin
                            state_q       <= SHIFT;
                            frame_start_q <= frame_end;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------ read-return datapath
    // vld_q tracks which cycles carry a requested column on pixel_rd_data.
    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] vld_d;
    logic                  arm_q;
    logic                  pclk_q;
    logic                  r_q;
    logic                  g_q;
    logic                  b_q;

    logic [LOG_POWER_MOD-1:0] r_field;
    logic [LOG_POWER_MOD-1:0] g_field;
    logic [LOG_POWER_MOD-1:0] b_field;

    assign r_field = pixel_rd_data[R_LSB +: LOG_POWER_MOD];
    assign g_field = pixel_rd_data[G_LSB +: LOG_POWER_MOD];
    assign b_field = pixel_rd_data[0 +: LOG_POWER_MOD];

    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = col_issue;
    end

    // Data is captured one cycle before the panel clock so r/g/b are stable
    // across the whole high phase.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vld_q  <= '0;
            arm_q  <= 1'b0;
            pclk_q <= 1'b0;
            r_q    <= 1'b0;
            g_q    <= 1'b0;
            b_q    <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            arm_q  <= vld_q[RD_LATENCY-1];
            pclk_q <= arm_q;
            if (vld_q[RD_LATENCY-1]) begin
                r_q <= r_field[plane_q];
                g_q <= g_field[plane_q];
                b_q <= b_field[plane_q];
            end
        end
    end

    assign pixel_rd_addr = addr_q;
    assign r_out         = r_q;
    assign g_out         = g_q;
    assign b_out         = b_q;
    assign panel_clk_out = pclk_q;
    assign latch_out     = latch_q;
    assign oe_n_out      = oe_n_q;
    assign row_addr_out  = row_out_q;
    assign frame_start   = frame_start_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_hub75_scan_reader.sv
// Bench for hub75_scan_reader: three instances (RD_LATENCY 2, 1, 4) share clock,
// reset and enable; each has its own buffer model with matching read latency.
module tb_hub75_scan_reader;

    localparam int NR = 16;
    localparam int NP = 128;
    localparam int NPH = 160;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic enable;
    logic word0_f00;
    logic mon_on;

    int errors = 0;
    int checks = 0;

    // a: RD_LATENCY=2, b: RD_LATENCY=1, c: RD_LATENCY=4
    logic [10:0] addr_a, addr_b, addr_c;
    logic [11:0] data_a, data_b, data_c;
    logic r_a, g_a, b_a, pc_a, lat_a, oe_a, fs_a, busy_a;
    logic r_b, g_b, b_b, pc_b, lat_b, oe_b, fs_b, busy_b;
    logic r_c, g_c, b_c, pc_c, lat_c, oe_c, fs_c, busy_c;
    logic [3:0] row_a, row_b, row_c;

    hub75_scan_reader #(.RD_LATENCY(2)) u_dut_a (
        .clk_in(clk), .rst_in(rst_n), .enable_in(enable),
        .pixel_rd_addr(addr_a), .pixel_rd_data(data_a),
        .r_out(r_a), .g_out(g_a), .b_out(b_a), .panel_clk_out(pc_a),
        .latch_out(lat_a), .oe_n_out(oe_a), .row_addr_out(row_a),
        .frame_start(fs_a), .busy(busy_a)
    );

    hub75_scan_reader #(.RD_LATENCY(1)) u_dut_b (
        .clk_in(clk), .rst_in(rst_n), .enable_in(enable),
        .pixel_rd_addr(addr_b), .pixel_rd_data(data_b),
        .r_out(r_b), .g_out(g_b), .b_out(b_b), .panel_clk_out(pc_b),
        .latch_out(lat_b), .oe_n_out(oe_b), .row_addr_out(row_b),
        .frame_start(fs_b), .busy(busy_b)
    );

    hub75_scan_reader #(.RD_LATENCY(4)) u_dut_c (
        .clk_in(clk), .rst_in(rst_n), .enable_in(enable),
        .pixel_rd_addr(addr_c), .pixel_rd_data(data_c),
        .r_out(r_c), .g_out(g_c), .b_out(b_c), .panel_clk_out(pc_c),
        .latch_out(lat_c), .oe_n_out(oe_c), .row_addr_out(row_c),
        .frame_start(fs_c), .busy(busy_c)
    );

    // Buffer contents: address k holds k, except word 0 may be forced to 12'hF00.
    function automatic logic [11:0] mem_word(input logic [10:0] a);
        if (word0_f00 && a == 11'd0) return 12'hF00;
        return {1'b0, a};
    endfunction

    logic [11:0] pipe_a [2];
    logic [11:0] pipe_c [4];

    always @(posedge clk) begin
        pipe_a[0] <= mem_word(addr_a);
        pipe_a[1] <= pipe_a[0];
        data_b    <= mem_word(addr_b);
        pipe_c[0] <= mem_word(addr_c);
        for (int i = 1; i < 4; i++) pipe_c[i] <= pipe_c[i-1];
    end
    assign data_a = pipe_a[1];
    assign data_c = pipe_c[3];

    // ------------------------------------------------ per-phase monitor
    int ph     [3];
    int ncl    [3];
    int nsh    [3];
    int bitbad [3];
    int glitch [3];
    int fscnt  [3];
    int clk_n   [3][NPH];
    int show_n  [3][NPH];
    int lat_row [3][NPH];
    logic [2:0] rgb_prev [3];

    logic       m_pc, m_lat, m_oe, m_fs;
    logic [2:0] m_rgb, m_exp;
    logic [3:0] m_row;
    logic [11:0] m_word;

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            case (d)
                0: begin m_pc = pc_a; m_lat = lat_a; m_oe = oe_a; m_fs = fs_a; m_rgb = {r_a, g_a, b_a}; m_row = row_a; end
                1: begin m_pc = pc_b; m_lat = lat_b; m_oe = oe_b; m_fs = fs_b; m_rgb = {r_b, g_b, b_b}; m_row = row_b; end
                default: begin m_pc = pc_c; m_lat = lat_c; m_oe = oe_c; m_fs = fs_c; m_rgb = {r_c, g_c, b_c}; m_row = row_c; end
            endcase
            if (!mon_on) begin
                ph[d] = 0; ncl[d] = 0; nsh[d] = 0;
                bitbad[d] = 0; glitch[d] = 0; fscnt[d] = 0;
            end else begin
                if (m_fs) fscnt[d]++;
                if (m_pc) begin
                    // phase p shows plane p%4 of row (p/4)%16; column = clocks so far
                    m_word = 12'((((ph[d] / 4) % NR) * NP) + ncl[d]);
                    m_exp  = {m_word[8 + ph[d] % 4], m_word[4 + ph[d] % 4], m_word[ph[d] % 4]};
                    if (m_rgb !== m_exp) bitbad[d]++;
                    if (m_rgb !== rgb_prev[d]) glitch[d]++;
                    ncl[d]++;
                end
                if (m_lat && ph[d] < NPH) begin
                    lat_row[d][ph[d]] = int'(m_row);
                    clk_n[d][ph[d]]   = ncl[d];
                    ncl[d] = 0;
                end
                if (!m_oe) begin
                    nsh[d]++;
                end else if (nsh[d] != 0) begin
                    if (ph[d] < NPH) show_n[d][ph[d]] = nsh[d];
                    nsh[d] = 0;
                    ph[d]++;
                end
            end
            rgb_prev[d] = m_rgb;
        end
    end

    // ------------------------------------------------ helpers
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        int dut;
        int phase;
        int exp_clocks;
        int exp_show;
        int exp_row;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int n;
        int pcs, oes, bsy;

        tbl = '{
            '{0,   0, 128,  64,  0},
            '{0,   1, 128, 128,  0},
            '{0,   2, 128, 256,  0},
            '{0,   3, 128, 512,  0},
            '{0,   4, 128,  64,  1},
            '{0,  22, 128, 256,  5},
            '{0,  63, 128, 512, 15},
            '{0,  64, 128,  64,  0},
            '{0, 127, 128, 512, 15},
            '{1,   0, 128,  64,  0},
            '{1,   3, 128, 512,  0},
            '{2,   0, 128,  64,  0},
            '{2,   3, 128, 512,  0}
        };

        rst_n = 1'b0; enable = 1'b0; word0_f00 = 1'b1; mon_on = 1'b0;
        repeat (3) tick();

        // ---- reset values
        check("rst_oe_n", oe_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_pclk", pc_a, 0);
        check("rst_latch", lat_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_row", row_a, 0);
        check("rst_frame_start", fs_a, 0);
        check("rst_rgb", {r_a, g_a, b_a}, 0);

        // ---- test 1: first column with word 0 = F00
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy_a, 0);
        enable = 1'b1;
        tick();                                   // SHIFT t=0
        check("t1_frame_start", fs_a, 1);
        check("t1_busy", busy_a, 1);
        check("t1_addr_col0", addr_a, 0);
        tick();                                   // t=1
        check("t1_frame_start_pulse", fs_a, 0);
        tick();                                   // t=2
        check("t1_addr_col1", addr_a, 1);
        n = 2;
        while (!pc_a && n < 20) begin tick(); n++; end
        check("t1_first_pclk_t", n, 4);
        check("t1_r", r_a, 1);
        check("t1_g", g_a, 0);
        check("t1_b", b_a, 0);

        // ---- tests 2/3/4/6: two frames, enable dropped at frame 2 row 5
        rst_n = 1'b0; enable = 1'b0;
        tick();
        word0_f00 = 1'b0;
        tick();
        mon_on = 1'b1;
        rst_n = 1'b1;
        tick();
        enable = 1'b1;
        n = 0;
        while (ph[0] < 84 && n < 60000) begin tick(); n++; end
        check("t4_reached_row5_frame2", int'(ph[0] >= 84), 1);
        enable = 1'b0;
        n = 0;
        while (busy_a && n < 40000) begin tick(); n++; end
        check("t4_idle_reached", int'(busy_a), 0);
        check("t4_phases_done", ph[0], 128);
        pcs = 0; oes = 0; bsy = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (pc_a) pcs++;
            if (!oe_a) oes++;
            if (busy_a) bsy++;
        end
        check("t4_pclk_after_idle", pcs, 0);
        check("t4_oe_low_after_idle", oes, 0);
        check("t4_busy_after_idle", bsy, 0);
        check("t4_phases_dut_lat1", ph[1], 128);
        check("t4_phases_dut_lat4", ph[2], 128);

        for (int i = 0; i < 13; i++) begin
            check($sformatf("clocks_d%0d_p%0d", tbl[i].dut, tbl[i].phase),
                  clk_n[tbl[i].dut][tbl[i].phase], tbl[i].exp_clocks);
            check($sformatf("show_d%0d_p%0d", tbl[i].dut, tbl[i].phase),
                  show_n[tbl[i].dut][tbl[i].phase], tbl[i].exp_show);
            check($sformatf("latch_row_d%0d_p%0d", tbl[i].dut, tbl[i].phase),
                  lat_row[tbl[i].dut][tbl[i].phase], tbl[i].exp_row);
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rgb_bits_d%0d", d), bitbad[d], 0);
            check($sformatf("rgb_change_at_pclk_d%0d", d), glitch[d], 0);
            check($sformatf("frame_starts_d%0d", d), fscnt[d], 2);
        end

        // ---- test 5: reset mid-SHIFT at column 60
        mon_on = 1'b0;
        enable = 1'b1;
        n = 0;
        while (addr_a != 11'd60 && n < 400) begin tick(); n++; end
        check("t5_reached_col60", int'(addr_a), 60);
        #2 rst_n = 1'b0;
        #1;
        check("t5_addr", addr_a, 0);
        check("t5_pclk", pc_a, 0);
        check("t5_latch", lat_a, 0);
        check("t5_oe_n", oe_a, 1);
        check("t5_rgb", {r_a, g_a, b_a}, 0);
        check("t5_row", row_a, 0);
        check("t5_frame_start", fs_a, 0);
        check("t5_busy", busy_a, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_restart_frame_start", fs_a, 1);
        check("t5_restart_addr", addr_a, 0);
        check("t5_restart_busy", busy_a, 1);
        tick(); tick();
        check("t5_restart_addr_col1", addr_a, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
